eda_task_sync_fifo_param: RTL and testbench
===========================================

// Module: eda_task_sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO: circular buffer with registered read data, occupancy count,
//  programmable almost-full/almost-empty flags, sticky overflow/underflow error flags.
//  Next-generation buffer for byte/word streams between producer and consumer blocks on SYSCLK.
//  All DEPTH entries are usable. Concurrent read and write are supported.
// PARAMETERS
//  WIDTH     8  data width in bits (>=1)
//  DEPTH     4  number of entries (>=2, any integer; not restricted to powers of two)
//  AF_LEVEL  3  ALMOST_FULL asserted when COUNT >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1  ALMOST_EMPTY asserted when COUNT <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  SYSCLK        in   1                   clock, rising edge
//  RST           in   1                   asynchronous reset, active-high
//  CLR           in   1                   synchronous flush, active-high
//  WR_EN         in   1                   write request
//  FIFO_IN       in   WIDTH               write data
//  RD_EN         in   1                   read request
//  FIFO_OUT      out  WIDTH               read data, registered
//  OUT_VALID     out  1                   FIFO_OUT carries newly popped word this cycle
//  EMPTY         out  1                   COUNT == 0
//  FULL          out  1                   COUNT == DEPTH
//  ALMOST_EMPTY  out  1                   COUNT <= AE_LEVEL
//  ALMOST_FULL   out  1                   COUNT >= AF_LEVEL
//  COUNT         out  $clog2(DEPTH+1)     current occupancy
//  OVERFLOW      out  1                   sticky: write rejected
//  UNDERFLOW     out  1                   sticky: read rejected
// BEHAVIOUR
//  - Reset (RST=1, async): wr_ptr=rd_ptr=0, COUNT=0, FIFO_OUT=0, OUT_VALID=0, OVERFLOW=0,
//    UNDERFLOW=0, so EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_LEVEL==0 ? 1 : 0).
//    Storage array is not reset. Reset mid-transfer discards all contents at once.
//  - Flags EMPTY/FULL/ALMOST_* are combinational decodes of the registered COUNT.
//  - Accepted write: WR_EN && (!FULL || rd_acc). Store at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
//  - Accepted read: rd_acc = RD_EN && !EMPTY. FIFO_OUT <= mem[rd_ptr]; OUT_VALID=1 on the
//    next cycle (1-cycle latency). rd_ptr wraps DEPTH-1 -> 0.
//  - With no accepted read: OUT_VALID=0 next cycle and FIFO_OUT holds its last value (not zeroed).
//  - Both accepted in one cycle: COUNT unchanged, both pointers advance.
//    When full, a concurrent read lets the write proceed.
//    When empty, the read is rejected: the write completes, UNDERFLOW sets, and there is no bypass.
//  - COUNT: +1 on write only, -1 on read only, unchanged otherwise. Never exceeds DEPTH or goes below 0.
//  - WR_EN while FULL without an accepted read: data dropped, OVERFLOW<=1.
//    RD_EN while EMPTY: UNDERFLOW<=1, FIFO_OUT unchanged, OUT_VALID=0.
//  - Error flags stay set until RST or CLR.
//  - CLR=1 (sync, overrides WR_EN/RD_EN): pointers=0, COUNT=0, OUT_VALID=0,
//    OVERFLOW=UNDERFLOW=0. FIFO_OUT holds its value.
//  - Ordering: words are read strictly in write order, including across pointer wrap.
// TESTING
//  1 Reset, DEPTH=4: write A1,A2,A3,A4. After the 4th edge COUNT=4, FULL=1, ALMOST_FULL=1.
//    Write A5 -> OVERFLOW=1, COUNT stays 4.
//  2 From (1): read 4 times -> FIFO_OUT=A1..A4 one cycle after each RD_EN with OUT_VALID=1, then EMPTY=1.
//    Read again -> UNDERFLOW=1, OUT_VALID=0, FIFO_OUT=A4.
//  3 Full FIFO, WR_EN=RD_EN=1 with data 0x55 -> FIFO_OUT=oldest word, COUNT stays 4, no OVERFLOW.
//    0x55 is read last.
//  4 Empty FIFO, WR_EN=RD_EN=1 with 0x3C -> COUNT=1, UNDERFLOW=1, OUT_VALID=0. Next read returns 0x3C.
//  5 Wrap: 10 cycles of 2 writes/2 reads with an incrementing pattern -> output sequence is
//    identical to input, COUNT never exceeds 2. Repeat with DEPTH=5 (non-power-of-2).
//  6 Assert RST mid-stream with COUNT=3 -> all outputs immediately at reset values.
//    Repeat with CLR -> same result on the next edge, except FIFO_OUT is held.

Source files
------------

// File: rtl/eda_task_sync_fifo_param.sv
// ============================================================================
// eda_task_sync_fifo_param
// ----------------------------------------------------------------------------
// Purpose:
//   Single-clock FIFO built as a circular buffer of DEPTH entries (any DEPTH
//   >= 2, not only powers of two). Read data is registered with a one-cycle
//   latency and qualified by o_out_valid. Occupancy count, empty/full and
//   programmable almost-empty/almost-full flags are provided, together with
//   sticky overflow/underflow error flags.
//
// Ports:
//   i_sysclk        clock, rising edge
//   i_rst           asynchronous reset, active-high
//   i_clr           synchronous flush, active-high, overrides i_wr_en/i_rd_en
//   i_wr_en         write request
//   i_fifo_in       write data [WIDTH-1:0]
//   i_rd_en         read request
//   o_fifo_out      registered read data [WIDTH-1:0]
//   o_out_valid     o_fifo_out holds a word popped on the previous edge
//   o_empty         count == 0
//   o_full          count == DEPTH
//   o_almost_empty  count <= AE_LEVEL
//   o_almost_full   count >= AF_LEVEL
//   o_count         current occupancy [$clog2(DEPTH+1)-1:0]
//   o_overflow      sticky: a write was rejected
//   o_underflow     sticky: a read was rejected
// ============================================================================
module eda_task_sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             i_sysclk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_fifo_in,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_fifo_out,
    output logic             o_out_valid,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_empty,
    output logic             o_almost_full,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int PW = $clog2(DEPTH);

    // Advance a pointer, wrapping explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_fifo_out;
    logic             r_out_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [CW-1:0]    w_count_nxt;

    assign w_empty  = (r_count == CW'(0));
    assign w_full   = (r_count == CW'(DEPTH));
    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write alongside an accepted read. A flush suppresses both transfers.
    assign w_rd_acc = i_rd_en && !w_empty && !i_clr;
    assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc) && !i_clr;

    // Next occupancy: simultaneous read and write leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge i_sysclk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_fifo_in;
        end
    end

    // Pointers, occupancy, read data register and sticky error flags.
    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_fifo_out  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_clr) begin
            // Flush keeps the last read word visible on o_fifo_out.
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_fifo_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= ptr_inc(r_rd_ptr);
            end
            if (i_wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            // Reading an empty FIFO fails even if a write lands this cycle.
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_fifo_out     = r_fifo_out;
    assign o_out_valid    = r_out_valid;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;
    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
    assign o_almost_full  = (r_count >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_eda_task_sync_fifo_param.sv
// ============================================================================
// tb_eda_task_sync_fifo_param
// ----------------------------------------------------------------------------
// Directed bench for eda_task_sync_fifo_param. Two instances share the input
// stimulus: dut4 (DEPTH=4, AF=3, AE=1) and dut5 (DEPTH=5, AF=4, AE=1).
// Most scenarios check dut4; the wrap scenario checks both after a reset.
// ============================================================================
module tb_eda_task_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;

    logic [7:0] out4, out5;
    logic       val4, val5;
    logic       emp4, emp5, ful4, ful5, ae4, ae5, af4, af5, ovf4, ovf5, unf4, unf5;
    logic [2:0] cnt4, cnt5;

    int errors = 0;
    int checks = 0;

    eda_task_sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut4 (
        .i_sysclk(clk), .i_rst(rst), .i_clr(clr), .i_wr_en(wr_en), .i_fifo_in(din),
        .i_rd_en(rd_en), .o_fifo_out(out4), .o_out_valid(val4), .o_empty(emp4),
        .o_full(ful4), .o_almost_empty(ae4), .o_almost_full(af4), .o_count(cnt4),
        .o_overflow(ovf4), .o_underflow(unf4)
    );

    eda_task_sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .i_sysclk(clk), .i_rst(rst), .i_clr(clr), .i_wr_en(wr_en), .i_fifo_in(din),
        .i_rd_en(rd_en), .o_fifo_out(out5), .o_out_valid(val5), .o_empty(emp5),
        .o_full(ful5), .o_almost_empty(ae5), .o_almost_full(af5), .o_count(cnt5),
        .o_overflow(ovf5), .o_underflow(unf5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        #12;
        checks++; if (cnt4 !== 3'd0)  begin errors++; $display("FAIL rst_count act=%0d exp=0", cnt4); end
        checks++; if (emp4 !== 1'b1)  begin errors++; $display("FAIL rst_empty act=%b exp=1", emp4); end
        checks++; if (ful4 !== 1'b0)  begin errors++; $display("FAIL rst_full act=%b exp=0", ful4); end
        checks++; if (ae4 !== 1'b1)   begin errors++; $display("FAIL rst_ae act=%b exp=1", ae4); end
        checks++; if (af4 !== 1'b0)   begin errors++; $display("FAIL rst_af act=%b exp=0", af4); end
        checks++; if (out4 !== 8'h00) begin errors++; $display("FAIL rst_out act=%h exp=00", out4); end
        checks++; if (val4 !== 1'b0)  begin errors++; $display("FAIL rst_valid act=%b exp=0", val4); end
        checks++; if (ovf4 !== 1'b0 || unf4 !== 1'b0) begin errors++; $display("FAIL rst_err act=%b%b exp=00", ovf4, unf4); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_overflow();
        logic [7:0] v;
        v = 8'hA1;
        wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = v;
            tick();
            checks++; if (cnt4 !== 3'(i)) begin errors++; $display("FAIL fill_count%0d act=%0d exp=%0d", i, cnt4, i); end
            checks++; if (ae4 !== (i <= 1)) begin errors++; $display("FAIL fill_ae%0d act=%b exp=%b", i, ae4, (i <= 1)); end
            checks++; if (af4 !== (i >= 3)) begin errors++; $display("FAIL fill_af%0d act=%b exp=%b", i, af4, (i >= 3)); end
            v = v + 8'h01;
        end
        checks++; if (ful4 !== 1'b1) begin errors++; $display("FAIL fill_full act=%b exp=1", ful4); end
        checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL fill_no_ovf act=%b exp=0", ovf4); end
        din = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++; if (ovf4 !== 1'b1)  begin errors++; $display("FAIL ovf_set act=%b exp=1", ovf4); end
        checks++; if (cnt4 !== 3'd4)  begin errors++; $display("FAIL ovf_count act=%0d exp=4", cnt4); end
    endtask

    task automatic test_drain_underflow();
        logic [7:0] e;
        e = 8'hA1;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out4 !== e)   begin errors++; $display("FAIL drain_data%0d act=%h exp=%h", i, out4, e); end
            checks++; if (val4 !== 1'b1) begin errors++; $display("FAIL drain_valid%0d act=%b exp=1", i, val4); end
            checks++; if (cnt4 !== 3'(3 - i)) begin errors++; $display("FAIL drain_count%0d act=%0d exp=%0d", i, cnt4, 3 - i); end
            e = e + 8'h01;
        end
        checks++; if (emp4 !== 1'b1) begin errors++; $display("FAIL drain_empty act=%b exp=1", emp4); end
        tick();
        rd_en = 1'b0;
        checks++; if (unf4 !== 1'b1)  begin errors++; $display("FAIL unf_set act=%b exp=1", unf4); end
        checks++; if (val4 !== 1'b0)  begin errors++; $display("FAIL unf_valid act=%b exp=0", val4); end
        checks++; if (out4 !== 8'hA4) begin errors++; $display("FAIL unf_hold act=%h exp=a4", out4); end
        checks++; if (ovf4 !== 1'b1)  begin errors++; $display("FAIL ovf_sticky act=%b exp=1", ovf4); end
        tick();
        checks++; if (unf4 !== 1'b1)  begin errors++; $display("FAIL unf_sticky act=%b exp=1", unf4); end
    endtask

    task automatic test_full_concurrent();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (ovf4 !== 1'b0 || unf4 !== 1'b0) begin errors++; $display("FAIL clr_err act=%b%b exp=00", ovf4, unf4); end
        checks++; if (out4 !== 8'hA4) begin errors++; $display("FAIL clr_hold act=%h exp=a4", out4); end
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h10 + 8'(i);
            tick();
        end
        rd_en = 1'b1;
        din = 8'h55;
        tick();
        wr_en = 1'b0;
        checks++; if (out4 !== 8'h10) begin errors++; $display("FAIL fullrw_data act=%h exp=10", out4); end
        checks++; if (val4 !== 1'b1)  begin errors++; $display("FAIL fullrw_valid act=%b exp=1", val4); end
        checks++; if (cnt4 !== 3'd4)  begin errors++; $display("FAIL fullrw_count act=%0d exp=4", cnt4); end
        checks++; if (ovf4 !== 1'b0)  begin errors++; $display("FAIL fullrw_ovf act=%b exp=0", ovf4); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = (i == 3) ? 8'h55 : 8'h11 + 8'(i);
            tick();
            checks++; if (out4 !== e) begin errors++; $display("FAIL fullrw_order%0d act=%h exp=%h", i, out4, e); end
        end
        rd_en = 1'b0;
        checks++; if (emp4 !== 1'b1) begin errors++; $display("FAIL fullrw_empty act=%b exp=1", emp4); end
    endtask

    task automatic test_empty_concurrent();
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks++; if (cnt4 !== 3'd1)  begin errors++; $display("FAIL emptyrw_count act=%0d exp=1", cnt4); end
        checks++; if (unf4 !== 1'b1)  begin errors++; $display("FAIL emptyrw_unf act=%b exp=1", unf4); end
        checks++; if (val4 !== 1'b0)  begin errors++; $display("FAIL emptyrw_valid act=%b exp=0", val4); end
        checks++; if (out4 !== 8'h55) begin errors++; $display("FAIL emptyrw_hold act=%h exp=55", out4); end
        tick();
        rd_en = 1'b0;
        checks++; if (out4 !== 8'h3C || val4 !== 1'b1) begin errors++; $display("FAIL emptyrw_read act=%h/%b exp=3c/1", out4, val4); end
        checks++; if (cnt4 !== 3'd0)  begin errors++; $display("FAIL emptyrw_count0 act=%0d exp=0", cnt4); end
    endtask

    task automatic test_wrap();
        logic [7:0] wv;
        logic [7:0] ev;
        pulse_reset();
        wv = 8'h20;
        ev = 8'h20;
        for (int it = 0; it < 10; it++) begin
            wr_en = 1'b1;
            for (int k = 0; k < 2; k++) begin
                din = wv;
                tick();
                wv = wv + 8'h01;
            end
            wr_en = 1'b0;
            checks++; if (cnt4 !== 3'd2 || cnt5 !== 3'd2) begin errors++; $display("FAIL wrap_count%0d act=%0d/%0d exp=2", it, cnt4, cnt5); end
            rd_en = 1'b1;
            for (int k = 0; k < 2; k++) begin
                tick();
                checks++; if (out4 !== ev || val4 !== 1'b1) begin errors++; $display("FAIL wrap_d4_%0d act=%h/%b exp=%h/1", it, out4, val4, ev); end
                checks++; if (out5 !== ev || val5 !== 1'b1) begin errors++; $display("FAIL wrap_d5_%0d act=%h/%b exp=%h/1", it, out5, val5, ev); end
                ev = ev + 8'h01;
            end
            rd_en = 1'b0;
        end
        checks++; if (emp4 !== 1'b1 || emp5 !== 1'b1 || unf4 !== 1'b0 || unf5 !== 1'b0) begin
            errors++; $display("FAIL wrap_end act=%b%b%b%b exp=1100", emp4, emp5, unf4, unf5);
        end
    endtask

    // Fill to full, overflow once, then pop one: count=3, out=first, valid=1.
    task automatic setup_three(input logic [7:0] base);
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = base + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        setup_three(8'h70);
        checks++; if (cnt4 !== 3'd3 || out4 !== 8'h70 || val4 !== 1'b1 || ovf4 !== 1'b1) begin
            errors++; $display("FAIL mid_setup act=%0d/%h/%b/%b exp=3/70/1/1", cnt4, out4, val4, ovf4);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cnt4 !== 3'd0 || emp4 !== 1'b1 || ful4 !== 1'b0 || ae4 !== 1'b1 || af4 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_flags act=%0d/%b%b%b%b exp=0/1010", cnt4, emp4, ful4, ae4, af4);
        end
        checks++; if (out4 !== 8'h00 || val4 !== 1'b0 || ovf4 !== 1'b0 || unf4 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out act=%h/%b%b%b exp=00/000", out4, val4, ovf4, unf4);
        end
        #1;
        rst = 1'b0;
        setup_three(8'h80);
        checks++; if (cnt4 !== 3'd3 || out4 !== 8'h80 || ovf4 !== 1'b1) begin
            errors++; $display("FAIL clr_setup act=%0d/%h/%b exp=3/80/1", cnt4, out4, ovf4);
        end
        clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        #1;
        checks++; if (cnt4 !== 3'd3) begin errors++; $display("FAIL clr_sync act=%0d exp=3", cnt4); end
        tick();
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (cnt4 !== 3'd0 || emp4 !== 1'b1 || val4 !== 1'b0 || ovf4 !== 1'b0 || unf4 !== 1'b0) begin
            errors++; $display("FAIL clr_state act=%0d/%b%b%b%b exp=0/1000", cnt4, emp4, val4, ovf4, unf4);
        end
        checks++; if (out4 !== 8'h80) begin errors++; $display("FAIL clr_out_hold act=%h exp=80", out4); end
        wr_en = 1'b1; din = 8'h99;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (out4 !== 8'h99 || val4 !== 1'b1) begin errors++; $display("FAIL clr_reuse act=%h/%b exp=99/1", out4, val4); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_concurrent();
        test_empty_concurrent();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
